rs_issue_scheduler: RTL and testbench

//  Reservation-station scheduler for one functional unit (scheduler side of dispatch_scheduler_if).

---
 rtl/rs_issue_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// -----------------------------------------------------------------------------
// rs_issue_scheduler
//   Reservation-station scheduler for one functional unit. Dispatched ops are
//   stored in a free entry together with a global dependency mask. The global
//   wakeup broadcast clears mask bits. The oldest ready entry is moved into a
//   one-deep valid/ready output register that feeds the FU.
//
// Ports (TOT = NUM_FUS*RS_ENTRIES):
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   disp_valid       dispatch request
//   disp_pkt         opaque payload to store
//   dependency_mask  bit g: op waits on global entry g
//   rs_entry_idx     entry the current dispatch will occupy
//   rs_full          no free entry, so a dispatch is not accepted
//   wakeup_vec       bit g: producer g completed this cycle
//   flush            synchronous squash of all station state
//   issue_valid      output register holds an issued op
//   issue_ready      FU accepts the op
//   issue_pkt        issued payload
//   issue_gid        global id of the issued entry
//   occupancy        valid entries in the station (output register excluded)
// -----------------------------------------------------------------------------
module rs_issue_scheduler #(
    parameter int NUM_FUS    = 4,
    parameter int RS_ENTRIES = 4,
    parameter int FU_ID      = 0,
    parameter int PKT_W      = 64,
    localparam int TOT       = NUM_FUS * RS_ENTRIES,
    localparam int IDX_W     = $clog2(RS_ENTRIES),
    localparam int GID_W     = $clog2(TOT),
    localparam int OCC_W     = $clog2(RS_ENTRIES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    input  logic [PKT_W-1:0] disp_pkt,
    input  logic [TOT-1:0]   dependency_mask,
    output logic [IDX_W-1:0] rs_entry_idx,
    output logic             rs_full,
    input  logic [TOT-1:0]   wakeup_vec,
    input  logic             flush,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [PKT_W-1:0] issue_pkt,
    output logic [GID_W-1:0] issue_gid,
    output logic [OCC_W-1:0] occupancy
);

    localparam int unsigned BASE_GID = FU_ID * RS_ENTRIES;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e              state_q, state_d;
    logic [RS_ENTRIES-1:0]   valid_q, valid_d;
    logic [TOT-1:0]          mask_q  [RS_ENTRIES];
    logic [TOT-1:0]          mask_d  [RS_ENTRIES];
    logic [PKT_W-1:0]        pkt_q   [RS_ENTRIES];
    logic [PKT_W-1:0]        pkt_d   [RS_ENTRIES];
    // older_q[i][j] = 1: entry i was allocated before entry j
    logic [RS_ENTRIES-1:0]   older_q [RS_ENTRIES];
    logic [RS_ENTRIES-1:0]   older_d [RS_ENTRIES];
    logic [PKT_W-1:0]        issue_pkt_q, issue_pkt_d;
    logic [GID_W-1:0]        issue_gid_q, issue_gid_d;

    logic [IDX_W-1:0]        alloc_idx;
    logic                    alloc_found;
    logic [RS_ENTRIES-1:0]   ready;
    logic [RS_ENTRIES-1:0]   sel_oh;
    logic [IDX_W-1:0]        sel_idx;
    logic                    any_ready;
    logic                    load_en;
    logic [TOT-1:0]          own_bit;
    logic [OCC_W-1:0]        occ_cnt;

    // Lowest-index free entry, from registered valid bits only.
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    // Oldest-ready select: an entry wins if no other ready entry is older.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            ready[i] = valid_q[i] & ~(|mask_q[i]);
        end
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            sel_oh[i] = ready[i];
            for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
                if (ready[j] && older_q[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        any_ready = |ready;
    end

    always_comb begin
        occ_cnt = '0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            occ_cnt = occ_cnt + OCC_W'(valid_q[i]);
        end
    end

    always_comb begin
        own_bit = '0;
        own_bit[GID_W'(BASE_GID) + GID_W'(alloc_idx)] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        mask_d      = mask_q;
        pkt_d       = pkt_q;
        older_d     = older_q;
        issue_pkt_d = issue_pkt_q;
        issue_gid_d = issue_gid_q;
        load_en     = (state_q == ST_EMPTY) || issue_ready;

        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (valid_q[i]) begin
                mask_d[i] = mask_q[i] & ~wakeup_vec;
            end
        end

        if (load_en) begin
            if (any_ready) begin
                state_d          = ST_FULL;
                issue_pkt_d      = pkt_q[sel_idx];
                issue_gid_d      = GID_W'(BASE_GID) + GID_W'(sel_idx);
                valid_d[sel_idx] = 1'b0;
            end else begin
                state_d = ST_EMPTY;
            end
        end

        // The allocated slot is invalid and the issued one valid, so the two
        // updates never touch the same entry.
        if (disp_valid && !rs_full) begin
            valid_d[alloc_idx] = 1'b1;
            pkt_d[alloc_idx]   = disp_pkt;
            mask_d[alloc_idx]  = dependency_mask & ~wakeup_vec & ~own_bit;
            older_d[alloc_idx] = '0;
            for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
                older_d[j][alloc_idx] = valid_q[j];
            end
        end

        if (flush) begin
            state_d = ST_EMPTY;
            valid_d = '0;
            for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
                mask_d[i]  = '0;
                older_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            valid_q     <= '0;
            issue_pkt_q <= '0;
            issue_gid_q <= '0;
            for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
                mask_q[i]  <= '0;
                pkt_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            issue_pkt_q <= issue_pkt_d;
            issue_gid_q <= issue_gid_d;
            for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
                mask_q[i]  <= mask_d[i];
                pkt_q[i]   <= pkt_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

    assign rs_entry_idx = alloc_idx;
    assign rs_full      = &valid_q;
    assign issue_valid  = (state_q == ST_FULL);
    assign issue_pkt    = issue_pkt_q;
    assign issue_gid    = issue_gid_q;
    assign occupancy    = occ_cnt;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rs_issue_scheduler
//   Directed bench for rs_issue_scheduler with FU_ID=3 (local gids 12..15),
//   so that mask bits 1, 5 and 9 are foreign producers and bit 12 is the
//   station's own entry 0.
// -----------------------------------------------------------------------------
module tb_rs_issue_scheduler;

    localparam int NUM_FUS    = 4;
    localparam int RS_ENTRIES = 4;
    localparam int FU_ID      = 3;
    localparam int PKT_W      = 16;
    localparam int TOT        = NUM_FUS * RS_ENTRIES;

    logic             clk;
    logic             rst;
    logic             disp_valid;
    logic [PKT_W-1:0] disp_pkt;
    logic [TOT-1:0]   dependency_mask;
    logic [1:0]       rs_entry_idx;
    logic             rs_full;
    logic [TOT-1:0]   wakeup_vec;
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [PKT_W-1:0] issue_pkt;
    logic [3:0]       issue_gid;
    logic [2:0]       occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    rs_issue_scheduler #(
        .NUM_FUS   (NUM_FUS),
        .RS_ENTRIES(RS_ENTRIES),
        .FU_ID     (FU_ID),
        .PKT_W     (PKT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .disp_valid     (disp_valid),
        .disp_pkt       (disp_pkt),
        .dependency_mask(dependency_mask),
        .rs_entry_idx   (rs_entry_idx),
        .rs_full        (rs_full),
        .wakeup_vec     (wakeup_vec),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_pkt      (issue_pkt),
        .issue_gid      (issue_gid),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PKT_W-1:0] p, input logic [TOT-1:0] m);
        disp_valid      = v;
        disp_pkt        = p;
        dependency_mask = m;
    endtask

    task automatic chk_st(input string tag, input int occ, input int full, input int idx);
        check({tag, "_occ"},  32'(occupancy),    32'(occ));
        check({tag, "_full"}, 32'(rs_full),      32'(full));
        check({tag, "_idx"},  32'(rs_entry_idx), 32'(idx));
    endtask

    task automatic chk_issue(input string tag, input int gid, input int pkt);
        check({tag, "_iv"},  32'(issue_valid), 32'd1);
        check({tag, "_gid"}, 32'(issue_gid),   32'(gid));
        check({tag, "_pkt"}, 32'(issue_pkt),   32'(pkt));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_ready = 1'b0; wakeup_vec = '0;
        drive(1'b0, '0, '0);

        // ---------------- reset values
        #2;
        check("rst_iv", 32'(issue_valid), 32'd0);
        check("rst_gid", 32'(issue_gid), 32'd0);
        check("rst_pkt", 32'(issue_pkt), 32'd0);
        chk_st("rst", 0, 0, 0);
        @(posedge clk); #1; rst = 1'b0;

        // ---------------- 1: four zero-mask dispatches, FU always ready
        issue_ready = 1'b1;
        drive(1'b1, 16'h00A0, '0); tick();
        check("t1_e1_iv", 32'(issue_valid), 32'd0);
        chk_st("t1_e1", 1, 0, 1);
        drive(1'b1, 16'h00A1, '0); tick();
        chk_issue("t1_e2", 12, 16'h00A0);
        chk_st("t1_e2", 1, 0, 0);
        drive(1'b1, 16'h00A2, '0); tick();
        chk_issue("t1_e3", 13, 16'h00A1);
        drive(1'b1, 16'h00A3, '0); tick();
        chk_issue("t1_e4", 12, 16'h00A2);
        drive(1'b0, '0, '0); tick();
        chk_issue("t1_e5", 13, 16'h00A3);
        chk_st("t1_e5", 0, 0, 0);
        tick();
        check("t1_e6_iv", 32'(issue_valid), 32'd0);

        // ---------------- 2: fill with entries blocked on gid 5
        drive(1'b1, 16'h00B0, 16'h0020); tick();
        drive(1'b1, 16'h00B1, 16'h0020); tick();
        drive(1'b1, 16'h00B2, 16'h0020); tick();
        chk_st("t2_3", 3, 0, 3);
        drive(1'b1, 16'h00B3, 16'h0020); tick();
        chk_st("t2_4", 4, 1, 0);
        check("t2_4_iv", 32'(issue_valid), 32'd0);
        drive(1'b1, 16'h00B4, '0); tick();           // refused while full
        chk_st("t2_ign", 4, 1, 0);
        wakeup_vec = 16'h0020; tick();               // still full, still refused
        wakeup_vec = '0;
        chk_st("t2_wake", 4, 1, 0);
        check("t2_wake_iv", 32'(issue_valid), 32'd0);
        tick();
        chk_issue("t2_i0", 12, 16'h00B0);
        chk_st("t2_i0", 3, 0, 0);
        tick();                                      // B4 lands in entry 0
        drive(1'b0, '0, '0);
        chk_issue("t2_i1", 13, 16'h00B1);
        chk_st("t2_i1", 3, 0, 1);
        tick();
        chk_issue("t2_i2", 14, 16'h00B2);
        tick();
        chk_issue("t2_i3", 15, 16'h00B3);
        tick();
        chk_issue("t2_i4", 12, 16'h00B4);
        chk_st("t2_i4", 0, 0, 0);
        tick();
        check("t2_end_iv", 32'(issue_valid), 32'd0);

        // ---------------- 3: same-cycle wakeup bypass, own-gid bit ignored
        drive(1'b1, 16'h00C0, 16'h0200); wakeup_vec = 16'h0200; tick();
        drive(1'b0, '0, '0); wakeup_vec = '0;
        check("t3_e1_iv", 32'(issue_valid), 32'd0);
        tick();
        chk_issue("t3_byp", 12, 16'h00C0);
        drive(1'b1, 16'h00C1, 16'h1000); tick();
        drive(1'b0, '0, '0);
        tick();
        chk_issue("t3_own", 12, 16'h00C1);
        tick();
        check("t3_end_iv", 32'(issue_valid), 32'd0);

        // ---------------- 4: FU backpressure
        issue_ready = 1'b0;
        drive(1'b1, 16'h00D0, '0); tick();
        drive(1'b1, 16'h00D1, '0); tick();
        chk_issue("t4_load", 12, 16'h00D0);
        drive(1'b1, 16'h00D2, '0); tick();
        drive(1'b0, '0, '0);
        chk_st("t4_fill", 2, 0, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_issue("t4_hold", 12, 16'h00D0);
            check("t4_hold_occ", 32'(occupancy), 32'd2);
        end
        issue_ready = 1'b1; tick();
        chk_issue("t4_rel1", 13, 16'h00D1);
        tick();
        chk_issue("t4_rel2", 12, 16'h00D2);
        tick();
        check("t4_end_iv", 32'(issue_valid), 32'd0);

        // ---------------- 5: entry 2 older than entry 0, woken together
        drive(1'b1, 16'h00F0, 16'h0002); tick();     // entry 0, waits on gid 1
        drive(1'b1, 16'h00F1, '0); tick();           // entry 1
        drive(1'b1, 16'h00F2, 16'h0020); tick();     // entry 2, waits on gid 5
        drive(1'b0, '0, '0);
        chk_issue("t5_f1", 13, 16'h00F1);
        wakeup_vec = 16'h0002; tick();
        wakeup_vec = '0;
        check("t5_blk_iv", 32'(issue_valid), 32'd0);
        tick();
        chk_issue("t5_f0", 12, 16'h00F0);
        drive(1'b1, 16'h00F3, 16'h0200); tick();     // entry 0 again, younger
        drive(1'b0, '0, '0);
        chk_st("t5_alloc", 2, 0, 1);
        wakeup_vec = 16'h0220; tick();
        wakeup_vec = '0;
        check("t5_wake_iv", 32'(issue_valid), 32'd0);
        tick();
        chk_issue("t5_old", 14, 16'h00F2);
        tick();
        chk_issue("t5_young", 12, 16'h00F3);
        tick();
        check("t5_end_iv", 32'(issue_valid), 32'd0);

        // ---------------- 6: flush, then asynchronous reset mid-issue
        issue_ready = 1'b0;
        drive(1'b1, 16'h0010, '0); tick();
        drive(1'b1, 16'h0011, '0); tick();
        drive(1'b1, 16'h0012, '0); tick();
        drive(1'b1, 16'h0013, '0); tick();
        chk_st("t6_pre", 3, 0, 3);
        chk_issue("t6_pre", 12, 16'h0010);
        drive(1'b1, 16'h0014, '0); flush = 1'b1; tick();
        flush = 1'b0; drive(1'b0, '0, '0);
        chk_st("t6_flush", 0, 0, 0);
        check("t6_flush_iv", 32'(issue_valid), 32'd0);
        issue_ready = 1'b1;
        drive(1'b1, 16'h0020, '0); tick();
        drive(1'b1, 16'h0021, '0); tick();
        drive(1'b0, '0, '0);
        chk_issue("t6_refill", 12, 16'h0020);
        #2; rst = 1'b1; #1;
        check("t6_rst_iv", 32'(issue_valid), 32'd0);
        check("t6_rst_gid", 32'(issue_gid), 32'd0);
        check("t6_rst_pkt", 32'(issue_pkt), 32'd0);
        chk_st("t6_rst", 0, 0, 0);
        @(posedge clk); #1; rst = 1'b0;
        drive(1'b1, 16'h0030, '0); tick();
        drive(1'b0, '0, '0);
        tick();
        chk_issue("t6_post", 12, 16'h0030);
        tick();
        check("t6_post_iv", 32'(issue_valid), 32'd0);
        chk_st("t6_post", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
